// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer : program-counter stage with valid/ack fetch handshake
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_sequencer #(
   parameter int                WIDTH    = 4,
   parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt_req,
   input  logic             jmp,
   input  logic [WIDTH-1:0] jmp_addr,
   input  logic             ack,
   output logic [WIDTH-1:0] pc,
   output logic             pc_valid,
   output logic [1:0]       state,
   output logic             wrap
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_RUN     = 2'b01,
      S_HALT    = 2'b10,
      S_INVALID = 2'b11
   } state_t;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_pc;
   logic             r_pc_valid;
   logic             r_wrap;

   state_t           w_state_next;
   logic [WIDTH-1:0] w_pc_next;
   logic             w_wrap_next;
   logic             w_xfer;

   assign w_xfer = r_pc_valid & ack;

   always_comb begin
      w_state_next = state_t'(r_state);
      w_pc_next    = r_pc;
      w_wrap_next  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_RUN;
         end
         S_RUN: begin
            // A transfer in the halting cycle still completes.
            if (w_xfer) begin
               w_pc_next   = jmp ? jmp_addr : r_pc + WIDTH'(1);
               w_wrap_next = ~jmp & (&r_pc);
            end
            if (halt_req) w_state_next = S_HALT;
         end
         S_HALT: begin
            if (start) w_state_next = S_RUN;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_pc_valid <= 1'b0;
         r_wrap     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_pc_valid <= (w_state_next == S_RUN);
         r_wrap     <= w_wrap_next;
      end
   end

   assign pc       = r_pc;
   assign pc_valid = r_pc_valid;
   assign state    = r_state;
   assign wrap     = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer : directed self-checking bench for pc_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       halt_req;
   logic       jmp;
   logic [3:0] jmp_addr;
   logic       ack;
   logic [3:0] pc;
   logic       pc_valid;
   logic [1:0] state;
   logic       wrap;

   int n_checks = 0;
   int n_fail   = 0;

   pc_sequencer #(.WIDTH(4), .RESET_PC(4'h0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .halt_req (halt_req),
      .jmp      (jmp),
      .jmp_addr (jmp_addr),
      .ack      (ack),
      .pc       (pc),
      .pc_valid (pc_valid),
      .state    (state),
      .wrap     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic h, input logic j,
                        input logic [3:0] a, input logic k);
      start = s; halt_req = h; jmp = j; jmp_addr = a; ack = k;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] e_pc, input logic e_v,
                          input logic [1:0] e_st, input logic e_w);
      chk({tag, ".pc"},    {28'd0, pc},       {28'd0, e_pc});
      chk({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, e_v});
      chk({tag, ".state"}, {30'd0, state},    {30'd0, e_st});
      chk({tag, ".wrap"},  {31'd0, wrap},     {31'd0, e_w});
   endtask

   initial begin
      rst_n = 1'b1;
      drive(0, 0, 0, 4'h0, 0);
      #1 rst_n = 1'b0;
      #10;
      chk_all("reset", 4'h0, 0, 2'b00, 0);
      rst_n = 1'b1;

      // IDLE ignores ack, jmp and halt_req
      drive(0, 1, 1, 4'hA, 1);
      step();
      chk_all("idle_ignore", 4'h0, 0, 2'b00, 0);

      // 1: start, then 5 acknowledged transfers
      drive(1, 0, 0, 4'h0, 0);
      step();
      chk_all("start", 4'h0, 1, 2'b01, 0);
      drive(0, 0, 0, 4'h0, 1);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_all($sformatf("seq%0d", i), 4'(i), 1, 2'b01, 0);
      end

      // 3: jumps around pc=5
      drive(0, 0, 1, 4'hC, 0);
      step();
      chk_all("jmp_noack", 4'h5, 1, 2'b01, 0);
      drive(0, 0, 0, 4'hC, 1);
      step();
      chk_all("ack_after_jmp", 4'h6, 1, 2'b01, 0);
      drive(0, 0, 1, 4'h5, 1);
      step();
      chk_all("jmp_to5", 4'h5, 1, 2'b01, 0);
      drive(0, 0, 1, 4'hC, 1);
      step();
      chk_all("jmp_toC", 4'hC, 1, 2'b01, 0);

      // 2: stall at pc=3
      drive(0, 0, 1, 4'h3, 1);
      step();
      chk_all("jmp_to3", 4'h3, 1, 2'b01, 0);
      drive(0, 0, 0, 4'h0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all($sformatf("stall%0d", i), 4'h3, 1, 2'b01, 0);
      end
      drive(0, 0, 0, 4'h0, 1);
      step();
      chk_all("unstall", 4'h4, 1, 2'b01, 0);

      // 4: wrap from 0xF
      drive(0, 0, 1, 4'hF, 1);
      step();
      chk_all("jmp_toF", 4'hF, 1, 2'b01, 0);
      drive(0, 0, 0, 4'h0, 1);
      step();
      chk_all("wrap_pulse", 4'h0, 1, 2'b01, 1);
      drive(0, 0, 0, 4'h0, 0);
      step();
      chk_all("wrap_clear", 4'h0, 1, 2'b01, 0);
      drive(0, 0, 1, 4'hF, 1);
      step();
      chk_all("jmp_toF2", 4'hF, 1, 2'b01, 0);
      drive(0, 0, 1, 4'h0, 1);
      step();
      chk_all("jmp_to0_nowrap", 4'h0, 1, 2'b01, 0);

      // 5: halt with concurrent transfer, then resume
      drive(0, 0, 1, 4'h7, 1);
      step();
      chk_all("jmp_to7", 4'h7, 1, 2'b01, 0);
      drive(0, 1, 0, 4'h0, 1);
      step();
      chk_all("halt_xfer", 4'h8, 0, 2'b10, 0);
      drive(0, 1, 1, 4'h2, 1);
      step();
      chk_all("halt_ignore", 4'h8, 0, 2'b10, 0);
      drive(1, 0, 0, 4'h0, 0);
      step();
      chk_all("resume", 4'h8, 1, 2'b01, 0);
      drive(1, 1, 0, 4'h0, 0);
      step();
      chk_all("halt_prio", 4'h8, 0, 2'b10, 0);
      drive(1, 0, 0, 4'h0, 0);
      step();
      chk_all("resume2", 4'h8, 1, 2'b01, 0);

      // 6: asynchronous reset mid-cycle, then illegal-state recovery
      drive(0, 0, 1, 4'h9, 1);
      step();
      chk_all("jmp_to9", 4'h9, 1, 2'b01, 0);
      drive(0, 0, 0, 4'h0, 1);
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_rst", 4'h0, 0, 2'b00, 0);
      #1 rst_n = 1'b1;
      drive(0, 0, 0, 4'h0, 0);
      step();
      chk_all("post_rst", 4'h0, 0, 2'b00, 0);
      #2;
      force dut.r_state = 2'b11;
      #1;
      chk("forced_state", {30'd0, state}, 32'd3);
      release dut.r_state;
      step();
      chk("illegal_recover", {30'd0, state}, 32'd0);
      chk("illegal_valid", {31'd0, pc_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
